// File: rtl/alu_datapath.sv
// alu_datapath
// Responder side of the ALU control-strobe interface. Holds the general
// register bank, the shared internal bus, the A/B operand latches, the ALU
// and the result latch. It executes whatever strobes the controller issues.
// It also watches strobe ordering, bus contention and register-index range,
// and records violations in sticky error bits.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   instr           [15:12] opcode, [11:6] param1 (dest/src1), [5:0] param2 (src2)
//   Gx_out1/Gx_out2 drive R[param1] / R[param2] onto the bus
//   ALU_outEN       drive the result latch onto the bus
//   ALUin1/ALUin2   capture the bus into A / B
//   ALU_outlach     capture ALU(A,B) into the result latch, update zero/carry
//   Gx_in           write the bus into R[param1]
//   done            end of instruction
//   ld_en/addr/data preload write (Gx_in takes priority)
//   dbg_addr/data   combinational debug read, 0 when out of range
//   bus             current internal bus value
//   zero, carry     flags of the last latched operation
//   op_done         one-cycle pulse after a correctly sequenced done
//   err             sticky {idx_err, bus_err, seq_err}
//   err_clr         synchronous clear of err (new errors win)
module alu_datapath #(
  parameter int NUM_REGS = 8,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   instr,
  input  logic          Gx_out1,
  input  logic          ALUin1,
  input  logic          Gx_out2,
  input  logic          ALUin2,
  input  logic          ALU_outlach,
  input  logic          ALU_outEN,
  input  logic          Gx_in,
  input  logic          done,
  input  logic          ld_en,
  input  logic [5:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [5:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] bus,
  output logic          zero,
  output logic          carry,
  output logic          op_done,
  output logic [2:0]    err,
  input  logic          err_clr
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0] NR = 7'(NUM_REGS);

  typedef enum logic [2:0] {S_IDLE, S_A, S_B, S_RES, S_WB} state_t;

  logic [DW-1:0] r_regs [NUM_REGS];
  logic [DW-1:0] r_a, r_b, r_res;
  logic          r_zero, r_carry, r_opDone;
  logic [2:0]    r_err;
  state_t        r_state;

  logic [3:0]    w_op;
  logic [5:0]    w_p1, w_p2;
  logic          w_p1Ok, w_p2Ok, w_ldOk, w_dbgOk;
  logic [DW-1:0] w_rd1, w_rd2, w_bus;
  logic          w_multiDrv, w_idxErr;
  logic [DW-1:0] w_aluRes;
  logic          w_aluCarry, w_opErr;
  logic [DW:0]   w_shl, w_shr, w_sum;
  logic [4:0]    w_strobes, w_expect;
  state_t        w_nextState, w_advance;
  logic          w_seqErr, w_legalDone;

  assign w_op   = instr[15:12];
  assign w_p1   = instr[11:6];
  assign w_p2   = instr[5:0];
  assign w_p1Ok  = {1'b0, w_p1} < NR;
  assign w_p2Ok  = {1'b0, w_p2} < NR;
  assign w_ldOk  = {1'b0, ld_addr} < NR;
  assign w_dbgOk = {1'b0, dbg_addr} < NR;

  assign w_rd1    = w_p1Ok ? r_regs[w_p1[IW-1:0]] : '0;
  assign w_rd2    = w_p2Ok ? r_regs[w_p2[IW-1:0]] : '0;
  assign dbg_data = w_dbgOk ? r_regs[dbg_addr[IW-1:0]] : '0;

  assign w_multiDrv = (Gx_out1 & Gx_out2) | (Gx_out1 & ALU_outEN) | (Gx_out2 & ALU_outEN);

  // Out-of-range reads, dropped Gx_in writes and dropped preloads all count
  // as index errors. A preload shadowed by Gx_in is ignored entirely.
  assign w_idxErr = (Gx_out1 & ~w_p1Ok) | (Gx_out2 & ~w_p2Ok) | (Gx_in & ~w_p1Ok)
                  | (ld_en & ~Gx_in & ~w_ldOk);

  // Bus mux: a single driver is passed through, contention forces zero.
  always_comb begin
    w_bus = '0;
    case ({ALU_outEN, Gx_out2, Gx_out1})
      3'b001:  w_bus = w_rd1;
      3'b010:  w_bus = w_rd2;
      3'b100:  w_bus = r_res;
      default: w_bus = '0;
    endcase
  end

  // The extra bit above A (shift left) or below A (shift right) catches the
  // last bit shifted out; a shift of zero leaves that bit clear.
  assign w_shl = {1'b0, r_a} << r_b[3:0];
  assign w_shr = {r_a, 1'b0} >> r_b[3:0];
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_aluRes   = '0;
    w_aluCarry = 1'b0;
    w_opErr    = 1'b0;
    case (w_op)
      4'b1001: begin w_aluRes = w_sum[DW-1:0]; w_aluCarry = w_sum[DW]; end
      4'b1010: begin w_aluRes = r_a - r_b;     w_aluCarry = r_a < r_b; end
      4'b1011: w_aluRes = r_a & r_b;
      4'b1100: w_aluRes = r_a | r_b;
      4'b1101: w_aluRes = r_a ^ r_b;
      4'b1110: begin w_aluRes = w_shl[DW-1:0]; w_aluCarry = w_shl[DW]; end
      4'b1111: begin w_aluRes = w_shr[DW:1];   w_aluCarry = w_shr[0];  end
      default: w_opErr = 1'b1;
    endcase
  end

  // Sequence tracker: each state accepts exactly one tracked strobe. Anything
  // else (wrong strobe or several at once) flags seq_err and returns to idle.
  assign w_strobes = {done, Gx_in, ALU_outlach, ALUin2, ALUin1};

  always_comb begin
    w_nextState = r_state;
    w_advance   = S_IDLE;
    w_expect    = 5'b00000;
    w_seqErr    = 1'b0;
    w_legalDone = 1'b0;
    case (r_state)
      S_IDLE:  begin w_expect = 5'b00001; w_advance = S_A;    end
      S_A:     begin w_expect = 5'b00010; w_advance = S_B;    end
      S_B:     begin w_expect = 5'b00100; w_advance = S_RES;  end
      S_RES:   begin w_expect = 5'b01000; w_advance = S_WB;   end
      S_WB:    begin w_expect = 5'b10000; w_advance = S_IDLE; end
      default: begin w_expect = 5'b00000; w_advance = S_IDLE; end
    endcase
    if (w_strobes != 5'b00000) begin
      if (w_strobes == w_expect) begin
        w_nextState = w_advance;
        w_legalDone = (r_state == S_WB);
      end else begin
        w_seqErr    = 1'b1;
        w_nextState = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_opDone <= 1'b0;
      r_err    <= 3'b000;
    end else begin
      r_state  <= w_nextState;
      r_opDone <= w_legalDone;
      r_err    <= (r_err & {3{~err_clr}})
                | {w_idxErr, w_multiDrv, w_seqErr | (ALU_outlach & w_opErr)};
    end
  end

  // Datapath registers act on their strobes regardless of tracker verdicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      if (ALUin1) r_a <= w_bus;
      if (ALUin2) r_b <= w_bus;
      if (ALU_outlach) begin
        r_res   <= w_aluRes;
        r_zero  <= (w_aluRes == '0);
        r_carry <= w_aluCarry;
      end
      if (Gx_in) begin
        if (w_p1Ok) r_regs[w_p1[IW-1:0]] <= w_bus;
      end else if (ld_en && w_ldOk) begin
        r_regs[ld_addr[IW-1:0]] <= ld_data;
      end
    end
  end

  assign bus     = w_bus;
  assign zero    = r_zero;
  assign carry   = r_carry;
  assign op_done = r_opDone;
  assign err     = r_err;

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath
// Directed scenarios plus randomized legal instructions for alu_datapath,
// checked against an arithmetic reference model of the register bank.
`timescale 1ns/1ps
module tb_alu_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        Gx_out1, ALUin1, Gx_out2, ALUin2, ALU_outlach, ALU_outEN, Gx_in, done;
  logic        ld_en;
  logic [5:0]  ld_addr, dbg_addr;
  logic [15:0] ld_data, dbg_data, bus;
  logic        zero, carry, op_done, err_clr;
  logic [2:0]  err;

  int errors = 0;
  int checks = 0;
  logic [15:0] mRegs [8];

  alu_datapath #(.NUM_REGS(8), .DW(16)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .Gx_out1(Gx_out1), .ALUin1(ALUin1), .Gx_out2(Gx_out2), .ALUin2(ALUin2),
    .ALU_outlach(ALU_outlach), .ALU_outEN(ALU_outEN), .Gx_in(Gx_in), .done(done),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .bus(bus),
    .zero(zero), .carry(carry), .op_done(op_done), .err(err), .err_clr(err_clr)
  );

  always #50 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clearStrobes;
    Gx_out1 = 0; ALUin1 = 0; Gx_out2 = 0; ALUin2 = 0;
    ALU_outlach = 0; ALU_outEN = 0; Gx_in = 0; done = 0;
    ld_en = 0; err_clr = 0;
  endtask

  // Reference ALU from the operation definitions, using plain integer math.
  task automatic aluRef(input int op, input int unsigned a, input int unsigned b,
                        output logic [15:0] res, output logic cy);
    int unsigned sh, t;
    sh = b % 16;
    res = 0; cy = 0;
    case (op)
      9:  begin t = a + b; res = 16'(t % 65536); cy = (t >= 65536); end
      10: begin res = 16'((a + 65536 - b) % 65536); cy = (a < b); end
      11: res = 16'(a & b);
      12: res = 16'(a | b);
      13: res = 16'(a ^ b);
      14: begin t = a * (32'd1 << sh); res = 16'(t % 65536);
                cy = (sh == 0) ? 1'b0 : 1'((t / 65536) % 2); end
      15: begin res = 16'(a / (32'd1 << sh));
                cy = (sh == 0) ? 1'b0 : 1'((a / (32'd1 << (sh - 1))) % 2); end
      default: begin res = 0; cy = 0; end
    endcase
  endtask

  task automatic preload(input int idx, input logic [15:0] val);
    ld_en = 1; ld_addr = 6'(idx); ld_data = val;
    step;
    ld_en = 0;
    if (idx < 8) mRegs[idx] = val;
  endtask

  // Issues a correctly ordered strobe sequence; returns just after the done edge.
  task automatic runInstr(input logic [15:0] ins);
    instr = ins;
    Gx_out1 = 1; ALUin1 = 1; step; Gx_out1 = 0; ALUin1 = 0;
    Gx_out2 = 1; ALUin2 = 1; step; Gx_out2 = 0; ALUin2 = 0;
    ALU_outlach = 1; step; ALU_outlach = 0;
    ALU_outEN = 1; Gx_in = 1; step; ALU_outEN = 0; Gx_in = 0;
    done = 1; step; done = 0;
  endtask

  task automatic test_reset;
    rst = 1; instr = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
    clearStrobes;
    step; step;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 6'(i); #1;
      checks++;
      if (dbg_data !== 16'h0) begin errors++;
        $display("[TB] FAIL reset_reg%0d got %h expected 0000", i, dbg_data); end
      mRegs[i] = 0;
    end
    checks++;
    if ({zero, carry, op_done, err} !== 6'b0) begin errors++;
      $display("[TB] FAIL reset_flags got %b expected 000000", {zero, carry, op_done, err}); end
    checks++;
    if (bus !== 16'h0) begin errors++;
      $display("[TB] FAIL reset_bus got %h expected 0000", bus); end
    rst = 0;
    step;
  endtask

  task automatic test_add;
    preload(1, 16'h0005); preload(2, 16'h0003);
    runInstr(16'h9042);
    checks++;
    if (op_done !== 1'b1) begin errors++;
      $display("[TB] FAIL add_opdone got %b expected 1", op_done); end
    dbg_addr = 1; #1;
    checks++;
    if (dbg_data !== 16'h0008) begin errors++;
      $display("[TB] FAIL add_result got %h expected 0008", dbg_data); end
    checks++;
    if ({zero, carry, err} !== 5'b0) begin errors++;
      $display("[TB] FAIL add_flags got %b expected 00000", {zero, carry, err}); end
    step;
    checks++;
    if (op_done !== 1'b0) begin errors++;
      $display("[TB] FAIL add_opdone_pulse got %b expected 0", op_done); end
    mRegs[1] = 16'h0008;
  endtask

  task automatic test_sub_wrap;
    preload(1, 16'h0003); preload(2, 16'h0005);
    runInstr(16'hA042);
    dbg_addr = 1; #1;
    checks++;
    if ({dbg_data, carry, zero} !== {16'hFFFE, 1'b1, 1'b0}) begin errors++;
      $display("[TB] FAIL sub_borrow got %h c=%b z=%b expected fffe c=1 z=0", dbg_data, carry, zero); end
    preload(1, 16'hFFFF); preload(2, 16'h0001);
    runInstr(16'h9042);
    dbg_addr = 1; #1;
    checks++;
    if ({dbg_data, carry, zero, err} !== {16'h0000, 1'b1, 1'b1, 3'b000}) begin errors++;
      $display("[TB] FAIL add_wrap got %h c=%b z=%b err=%b expected 0000 c=1 z=1 err=000",
               dbg_data, carry, zero, err); end
    mRegs[1] = 16'h0000;
  endtask

  task automatic test_shift;
    preload(1, 16'h8001); preload(2, 16'h0001);
    runInstr(16'hE042);
    dbg_addr = 1; #1;
    checks++;
    if ({dbg_data, carry} !== {16'h0002, 1'b1}) begin errors++;
      $display("[TB] FAIL shl got %h c=%b expected 0002 c=1", dbg_data, carry); end
    preload(1, 16'hA5C3); preload(2, 16'h0010);
    runInstr(16'hF042);
    dbg_addr = 1; #1;
    checks++;
    if ({dbg_data, carry} !== {16'hA5C3, 1'b0}) begin errors++;
      $display("[TB] FAIL shr_zero got %h c=%b expected a5c3 c=0", dbg_data, carry); end
    mRegs[1] = 16'hA5C3;
  endtask

  task automatic test_seq_err;
    preload(1, 16'h0010); preload(2, 16'h0004);
    instr = 16'hA042;
    Gx_out2 = 1; ALUin2 = 1; step; Gx_out2 = 0; ALUin2 = 0;
    checks++;
    if ({err, op_done} !== 4'b0010) begin errors++;
      $display("[TB] FAIL seq_err got err=%b op_done=%b expected err=001 op_done=0", err, op_done); end
    Gx_out1 = 1; ALUin1 = 1; step; Gx_out1 = 0; ALUin1 = 0;
    ALU_outlach = 1; step; ALU_outlach = 0;
    ALU_outEN = 1; #1;
    checks++;
    if (bus !== 16'h000C) begin errors++;
      $display("[TB] FAIL seq_b_captured got %h expected 000c", bus); end
    ALU_outEN = 0;
    err_clr = 1; done = 1; step; err_clr = 0; done = 0;
    checks++;
    if (err !== 3'b001) begin errors++;
      $display("[TB] FAIL clr_vs_new got %b expected 001", err); end
    err_clr = 1; step; err_clr = 0;
    checks++;
    if (err !== 3'b000) begin errors++;
      $display("[TB] FAIL err_clr got %b expected 000", err); end
  endtask

  task automatic test_bus_idx;
    instr = 16'h9042;
    Gx_out1 = 1; ALU_outEN = 1; #1;
    checks++;
    if (bus !== 16'h0) begin errors++;
      $display("[TB] FAIL contention_bus got %h expected 0000", bus); end
    step; Gx_out1 = 0; ALU_outEN = 0;
    checks++;
    if (err !== 3'b010) begin errors++;
      $display("[TB] FAIL bus_err got %b expected 010", err); end
    err_clr = 1; step; err_clr = 0;
    instr = {4'h9, 6'd10, 6'd2};
    Gx_out2 = 1; Gx_in = 1; step; Gx_out2 = 0; Gx_in = 0;
    checks++;
    if (err[2] !== 1'b1) begin errors++;
      $display("[TB] FAIL idx_err got %b expected 1xx", err); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 6'(i); #1;
      checks++;
      if (dbg_data !== mRegs[i]) begin errors++;
        $display("[TB] FAIL idx_nowrite_r%0d got %h expected %h", i, dbg_data, mRegs[i]); end
    end
    dbg_addr = 10; #1;
    checks++;
    if (dbg_data !== 16'h0) begin errors++;
      $display("[TB] FAIL dbg_oor got %h expected 0000", dbg_data); end
    err_clr = 1; step; err_clr = 0;
  endtask

  task automatic test_ld_priority;
    preload(3, 16'h1111); preload(4, 16'h2222);
    err_clr = 1; step; err_clr = 0;
    instr = {4'h9, 6'd3, 6'd4};
    Gx_out2 = 1; Gx_in = 1; ld_en = 1; ld_addr = 3; ld_data = 16'h3333;
    step; clearStrobes;
    dbg_addr = 3; #1;
    checks++;
    if (dbg_data !== 16'h2222) begin errors++;
      $display("[TB] FAIL gx_in_wins got %h expected 2222", dbg_data); end
    mRegs[3] = 16'h2222;
    err_clr = 1; step; err_clr = 0;
    preload(9, 16'h5555);
    checks++;
    if (err !== 3'b100) begin errors++;
      $display("[TB] FAIL ld_oor got %b expected 100", err); end
    err_clr = 1; step; err_clr = 0;
  endtask

  task automatic test_reset_mid;
    preload(1, 16'h0005); preload(2, 16'h0003);
    instr = 16'h9042;
    Gx_out1 = 1; ALUin1 = 1; step; Gx_out1 = 0; ALUin1 = 0;
    Gx_out2 = 1; ALUin2 = 1; step; Gx_out2 = 0; ALUin2 = 0;
    ALU_outlach = 1; step; ALU_outlach = 0;
    #10 rst = 1; #1;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 6'(i); #1;
      checks++;
      if (dbg_data !== 16'h0) begin errors++;
        $display("[TB] FAIL midreset_r%0d got %h expected 0000", i, dbg_data); end
      mRegs[i] = 0;
    end
    checks++;
    if ({zero, carry, op_done, err} !== 6'b0) begin errors++;
      $display("[TB] FAIL midreset_flags got %b expected 000000", {zero, carry, op_done, err}); end
    step; rst = 0;
    step;
    preload(1, 16'h1234); preload(2, 16'h0101);
    runInstr(16'h9042);
    dbg_addr = 1; #1;
    checks++;
    if ({dbg_data, op_done, err} !== {16'h1335, 1'b1, 3'b000}) begin errors++;
      $display("[TB] FAIL post_reset_add got %h op_done=%b err=%b expected 1335 1 000",
               dbg_data, op_done, err); end
    mRegs[1] = 16'h1335;
    step;
  endtask

  task automatic test_random;
    logic [15:0] expRes;
    logic        expCy;
    int          op, p1, p2;
    for (int n = 0; n < 24; n++) begin
      op = int'($urandom_range(15, 9));
      p1 = int'($urandom_range(7, 0));
      p2 = int'($urandom_range(7, 0));
      preload(p1, 16'($urandom));
      preload(p2, 16'($urandom));
      aluRef(op, int'(mRegs[p1]), int'(mRegs[p2]), expRes, expCy);
      runInstr({4'(op), 6'(p1), 6'(p2)});
      mRegs[p1] = expRes;
      dbg_addr = 6'(p1); #1;
      checks++;
      if ({dbg_data, carry, zero, op_done, err} !==
          {expRes, expCy, expRes == 16'h0, 1'b1, 3'b000}) begin errors++;
        $display("[TB] FAIL rand%0d op=%0d got r=%h c=%b z=%b od=%b err=%b expected r=%h c=%b z=%b od=1 err=000",
                 n, op, dbg_data, carry, zero, op_done, err, expRes, expCy, expRes == 16'h0); end
      step;
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_wrap;
    test_shift;
    test_seq_err;
    test_bus_idx;
    test_ld_priority;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
